// File: rtl/rprelu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rprelu_pkg
// Description : Shared types and defaults for the RPReLU parameter-load
//               controller: load FSM state encoding, default sizing and a
//               counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rprelu_pkg;

  localparam int DEF_CHANNEL_NUM = 128;
  localparam int DEF_PARA_WIDTH  = 16;

  // Load sequencing: one state per parameter bank, plus a single swap cycle.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_BETA  = 3'd1,
    LD_GAMMA = 3'd2,
    LD_ZETA  = 3'd3,
    SWAP     = 3'd4
  } state_e;

  // Channel index width; a one-channel build still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : rprelu_pkg
`default_nettype wire

// File: rtl/rprelu_param_bank.sv
`default_nettype none
// ============================================================================
// Module      : rprelu_param_bank
// Description : One shadow/active register pair for a single per-channel
//               parameter (beta, gamma or zeta). Serial writes land only in
//               the shadow bank; a swap copies the whole shadow bank into the
//               active bank in one cycle.
// Ports       : clk, rstn      - clock, async active-low reset
//               wr_en          - write wr_data into shadow[wr_idx]
//               wr_idx         - channel index of the write
//               wr_data        - parameter word (stored bit-exact)
//               swap           - copy shadow bank into active bank
//               active         - active bank, one word per channel
// Revision    : 1.0 - initial release
// ============================================================================
module rprelu_param_bank
  import rprelu_pkg::*;
#(
  parameter int CHANNEL_NUM = DEF_CHANNEL_NUM,
  parameter int PARA_WIDTH  = DEF_PARA_WIDTH,
  localparam int IDX_W      = cnt_width(CHANNEL_NUM)
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   wr_en,
  input  logic [IDX_W-1:0]                       wr_idx,
  input  logic [PARA_WIDTH-1:0]                  wr_data,
  input  logic                                   swap,
  output logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0] active
);

  logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0] shadow_q;
  logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0] active_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow_q <= '0;
    end else if (wr_en) begin
      shadow_q[wr_idx] <= wr_data;
    end
  end

  // The controller never writes and swaps in the same cycle, so the swap
  // always sees a fully settled shadow bank.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active_q <= '0;
    end else if (swap) begin
      active_q <= shadow_q;
    end
  end

  assign active = active_q;

endmodule : rprelu_param_bank
`default_nettype wire

// File: rtl/rprelu_param_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rprelu_param_ctrl
// Description : Parameter-load controller and flow gate for the per-channel
//               RPReLU stage. Accepts beta[0..N-1], gamma[0..N-1],
//               zeta[0..N-1] as one serial valid/ready stream into shadow
//               banks, swaps them into the active banks in a single cycle,
//               and stalls upstream BN data until a complete set is active
//               and during the swap cycle itself.
// Ports       : clk, rstn                   - clock, async active-low reset
//               load_start                  - request a new parameter load
//               para_in_valid/para_in/_ready- serial parameter word stream
//               data_in_valid/data_in_ready - upstream BN data handshake
//               rprelu_valid                - accepted data to datapath
//               beta_out/gamma_out/zeta_out - active parameter banks
//               params_ready                - active bank holds a full set
//               load_busy                   - load in progress
//               load_done                   - one-cycle pulse on swap
// Revision    : 1.0 - initial release
// ============================================================================
module rprelu_param_ctrl
  import rprelu_pkg::*;
#(
  parameter int CHANNEL_NUM = DEF_CHANNEL_NUM,
  parameter int PARA_WIDTH  = DEF_PARA_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   load_start,
  input  logic                                   para_in_valid,
  input  logic [PARA_WIDTH-1:0]                  para_in,
  output logic                                   para_in_ready,
  input  logic                                   data_in_valid,
  output logic                                   data_in_ready,
  output logic                                   rprelu_valid,
  output logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0] beta_out,
  output logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0] gamma_out,
  output logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0] zeta_out,
  output logic                                   params_ready,
  output logic                                   load_busy,
  output logic                                   load_done
);

  localparam int CNT_W = cnt_width(CHANNEL_NUM);
  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(CHANNEL_NUM - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   ch_cnt_q, ch_cnt_d;
  logic               params_ready_q, params_ready_d;

  logic               xfer;
  logic               last_ch;
  logic               in_swap;
  logic               wr_beta, wr_gamma, wr_zeta;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= IDLE;
      ch_cnt_q       <= '0;
      params_ready_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ch_cnt_q       <= ch_cnt_d;
      params_ready_q <= params_ready_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    ch_cnt_d       = ch_cnt_q;
    params_ready_d = params_ready_q;
    para_in_ready  = 1'b0;
    in_swap        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d  = LD_BETA;
          ch_cnt_d = '0;
        end
      end
      LD_BETA, LD_GAMMA, LD_ZETA: begin
        para_in_ready = 1'b1;
        if (para_in_valid) begin
          if (ch_cnt_q == LAST_CH) begin
            ch_cnt_d = '0;
            unique case (state_q)
              LD_BETA:  state_d = LD_GAMMA;
              LD_GAMMA: state_d = LD_ZETA;
              default:  state_d = SWAP;
            endcase
          end else begin
            ch_cnt_d = ch_cnt_q + CNT_W'(1);
          end
        end
      end
      SWAP: begin
        // load_start is deliberately not looked at here.
        in_swap        = 1'b1;
        params_ready_d = 1'b1;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign xfer     = para_in_valid & para_in_ready;
  assign last_ch  = (ch_cnt_q == LAST_CH);
  assign wr_beta  = xfer & (state_q == LD_BETA);
  assign wr_gamma = xfer & (state_q == LD_GAMMA);
  assign wr_zeta  = xfer & (state_q == LD_ZETA);

  // Old active set keeps serving data while the shadow banks fill; only the
  // swap cycle itself is blocked so no beat straddles two parameter sets.
  assign data_in_ready = params_ready_q & ~in_swap;
  assign rprelu_valid  = data_in_valid & data_in_ready;
  assign params_ready  = params_ready_q;
  assign load_busy     = (state_q != IDLE);
  assign load_done     = in_swap;

  // --------------------------------------------------------------------------
  // Parameter banks
  // --------------------------------------------------------------------------
  rprelu_param_bank #(
    .CHANNEL_NUM (CHANNEL_NUM),
    .PARA_WIDTH  (PARA_WIDTH)
  ) u_bank_beta (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_beta),
    .wr_idx  (ch_cnt_q),
    .wr_data (para_in),
    .swap    (in_swap),
    .active  (beta_out)
  );

  rprelu_param_bank #(
    .CHANNEL_NUM (CHANNEL_NUM),
    .PARA_WIDTH  (PARA_WIDTH)
  ) u_bank_gamma (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_gamma),
    .wr_idx  (ch_cnt_q),
    .wr_data (para_in),
    .swap    (in_swap),
    .active  (gamma_out)
  );

  rprelu_param_bank #(
    .CHANNEL_NUM (CHANNEL_NUM),
    .PARA_WIDTH  (PARA_WIDTH)
  ) u_bank_zeta (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_zeta),
    .wr_idx  (ch_cnt_q),
    .wr_data (para_in),
    .swap    (in_swap),
    .active  (zeta_out)
  );

  // last_ch mirrors the in-FSM compare; kept as a named signal for debug.
  logic unused_last_ch;
  assign unused_last_ch = last_ch;

endmodule : rprelu_param_ctrl
`default_nettype wire

// File: tb/tb_rprelu_param_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rprelu_param_ctrl
// Description : Self-checking bench for rprelu_param_ctrl (4 channels,
//               16-bit words). Stimulus pushes each expected parameter set
//               into a queue; a monitor pops it when the DUT signals a swap
//               and tracks a cycle-level model of the load protocol.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rprelu_param_ctrl;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int NW = 3 * N;

  typedef logic [NW-1:0][W-1:0] set_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic load_start = 1'b0;
  logic para_in_valid = 1'b0;
  logic [W-1:0] para_in = '0;
  logic data_in_valid = 1'b0;
  logic para_in_ready, data_in_ready, rprelu_valid;
  logic params_ready, load_busy, load_done;
  logic [N-1:0][W-1:0] beta_out, gamma_out, zeta_out;

  int checks = 0;
  int errors = 0;
  int dv_mode = 1;   // 1: data_in_valid held high, 0: random

  set_t exp_q[$];

  // Reference model of the protocol, in terms of words counted per load.
  bit   m_loading = 0;
  bit   m_swap    = 0;
  bit   m_have    = 0;
  int   m_words   = 0;
  set_t m_act     = '0;

  rprelu_param_ctrl #(
    .CHANNEL_NUM (N),
    .PARA_WIDTH  (W)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .load_start    (load_start),
    .para_in_valid (para_in_valid),
    .para_in       (para_in),
    .para_in_ready (para_in_ready),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .rprelu_valid  (rprelu_valid),
    .beta_out      (beta_out),
    .gamma_out     (gamma_out),
    .zeta_out      (zeta_out),
    .params_ready  (params_ready),
    .load_busy     (load_busy),
    .load_done     (load_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor / scoreboard: samples on the falling edge.
  // --------------------------------------------------------------------------
  initial begin
    bit exp_dir;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        m_loading = 0; m_swap = 0; m_have = 0; m_words = 0; m_act = '0;
        chk("reset_outputs",
            {para_in_ready, data_in_ready, rprelu_valid, params_ready, load_busy, load_done},
            6'b0);
        chk("reset_banks", {zeta_out, gamma_out, beta_out}, '0);
      end else begin
        exp_dir = m_have && !m_swap;
        chk("para_in_ready", para_in_ready, m_loading);
        chk("load_busy", load_busy, m_loading || m_swap);
        chk("load_done", load_done, m_swap);
        chk("params_ready", params_ready, m_have);
        chk("data_in_ready", data_in_ready, exp_dir);
        chk("rprelu_valid", rprelu_valid, data_in_valid && exp_dir);
        chk("active_banks", {zeta_out, gamma_out, beta_out}, m_act);

        // DUT presents a completed load: pop the expected set.
        if (load_done) begin
          chk("scoreboard_nonempty", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) m_act = exp_q.pop_front();
        end

        if (m_swap) begin
          m_swap = 0;
          m_have = 1;
        end else if (m_loading) begin
          if (para_in_valid) begin
            m_words++;
            if (m_words == NW) begin
              m_loading = 0;
              m_swap    = 1;
            end
          end
        end else if (load_start) begin
          m_loading = 1;
          m_words   = 0;
        end
      end
    end
  end

  // Upstream BN data source.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      data_in_valid = (dv_mode == 1) ? 1'b1 : 1'($urandom & 1);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  // Returns in the SWAP cycle (or after reset release when aborted).
  task automatic do_load(input set_t s, input int gap_pct, input bit glitch,
                         input bit swap_start, input int abort_after);
    int idx   = 0;
    int guard = 0;
    bit v, acc;
    exp_q.push_back(s);
    @(posedge clk); #1;
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    while (idx < NW) begin
      if (abort_after >= 0 && idx == abort_after) begin
        para_in_valid = 1'b0;
        rstn = 1'b0;
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b1;
        return;
      end
      v = ($urandom_range(99) >= 32'(gap_pct));
      para_in_valid = v;
      para_in       = s[idx];
      load_start    = glitch && ($urandom_range(7) == 0);
      @(negedge clk);
      acc = v && para_in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
      if (guard > 500) begin
        checks++; errors++;
        $display("FAIL load_timeout: accepted %0d words, required %0d", idx, NW);
        break;
      end
    end
    // Junk word left pending: must not be consumed in SWAP or IDLE.
    para_in_valid = 1'b1;
    para_in       = W'($urandom);
    load_start    = swap_start;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
    load_start    = 1'b0;
    para_in_valid = 1'b0;
  endtask

  initial begin
    set_t s;
    dv_mode = 1;
    rstn    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    // No parameters yet: data must stay stalled.
    idle(10);

    for (int k = 0; k < NW; k++) s[k] = W'(k + 1);
    do_load(s, 0, 0, 0, -1);
    idle(3);

    // Second load with data flowing; load_start in SWAP is ignored and the
    // one in the following IDLE cycle starts the next load.
    for (int k = 0; k < NW; k++) s[k] = W'(k + 13);
    do_load(s, 0, 0, 1, -1);

    dv_mode = 0;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NW; k++) s[k] = W'($urandom);
      if (r == 0) begin
        s[0]    = 16'h8000;
        s[N]    = 16'hFFFF;
        s[NW-1] = 16'hFFFF;
        s[NW-2] = 16'h8001;
      end
      do_load(s, 30, 1, r[0], -1);
    end
    idle(3);

    // Abort after 6 words, then a clean full load.
    for (int k = 0; k < NW; k++) s[k] = W'($urandom);
    do_load(s, 0, 0, 0, 6);
    idle(4);
    for (int k = 0; k < NW; k++) s[k] = W'($urandom);
    do_load(s, 20, 0, 0, -1);
    idle(5);

    chk("queue_drained", exp_q.size(), 0);
    chk("final_params_ready", params_ready, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_rprelu_param_ctrl
`default_nettype wire
